// File: rtl/bit_count_accumulator_if.sv
// Beat-in / frame-result-out handshake bundle for bit_count_accumulator.
// BIT_COUNT_ACCUMULATOR_THRESHOLD_EN adds the threshold input and the above flag.
interface bit_count_accumulator_if #(
  parameter int unsigned WID_CountRange = 32,
  parameter int unsigned WID_Accum      = 16
);
  logic [WID_CountRange-1:0] local_BCA_bitstream;
  logic                      local_BCA_valid;
  logic                      local_BCA_last;
  logic                      BCA_local_ready;
  logic [WID_Accum-1:0]      BCA_local_result;
  logic [WID_Accum-1:0]      BCA_local_beats;
  logic                      BCA_local_overflow;
  logic                      BCA_local_valid;
  logic                      local_BCA_ready;
`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
  logic [WID_Accum-1:0]      local_BCA_threshold;
  logic                      BCA_local_above;

  modport master (
    output local_BCA_bitstream, local_BCA_valid, local_BCA_last, local_BCA_ready,
    output local_BCA_threshold,
    input  BCA_local_ready, BCA_local_result, BCA_local_beats, BCA_local_overflow,
    input  BCA_local_valid, BCA_local_above
  );

  modport slave (
    input  local_BCA_bitstream, local_BCA_valid, local_BCA_last, local_BCA_ready,
    input  local_BCA_threshold,
    output BCA_local_ready, BCA_local_result, BCA_local_beats, BCA_local_overflow,
    output BCA_local_valid, BCA_local_above
  );
`else
  modport master (
    output local_BCA_bitstream, local_BCA_valid, local_BCA_last, local_BCA_ready,
    input  BCA_local_ready, BCA_local_result, BCA_local_beats, BCA_local_overflow,
    input  BCA_local_valid
  );

  modport slave (
    input  local_BCA_bitstream, local_BCA_valid, local_BCA_last, local_BCA_ready,
    output BCA_local_ready, BCA_local_result, BCA_local_beats, BCA_local_overflow,
    output BCA_local_valid
  );
`endif
endinterface

// File: rtl/bit_count_accumulator.sv
// Streaming popcount: registered adder tree per beat, saturating per-frame accumulation.
// Optional threshold compare enabled by BIT_COUNT_ACCUMULATOR_THRESHOLD_EN.
module bit_count_accumulator #(
  parameter int unsigned WID_CountRange  = 32,
  parameter int unsigned WID_CountResult = $clog2(WID_CountRange + 1),
  parameter int unsigned WID_Accum       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_count_accumulator_if.slave bus
);

  localparam int unsigned NumLayers = $clog2(WID_CountRange);
  localparam int unsigned PadWidth  = 1 << NumLayers;
  localparam logic [WID_Accum:0] OneWide = 1;

  logic stall;
  logic out_valid_q, out_valid_d;

  // A held result blocks the whole pipeline, so nothing upstream can be overwritten.
  assign stall               = out_valid_q & ~bus.local_BCA_ready;
  assign bus.BCA_local_ready = ~stall;

  logic [PadWidth-1:0] beat_pad;
  assign beat_pad = PadWidth'(bus.local_BCA_bitstream);

  // Layer k folds pairs of k-bit fields into (k+1)-bit fields.
  for (genvar k = 1; k <= NumLayers; k++) begin : g_layer
    localparam int unsigned NumOut = PadWidth >> k;
    localparam int unsigned InW    = k;
    localparam int unsigned OutW   = k + 1;

    logic [2*NumOut*InW-1:0] src;
    logic                    src_vld;
    logic                    src_last;
    logic [NumOut*OutW-1:0]  sum_d;
    logic [NumOut*OutW-1:0]  sum_q;
    logic                    vld_q;
    logic                    last_q;
`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
    logic [WID_Accum-1:0]    src_thr;
    logic [WID_Accum-1:0]    thr_q;
`endif

    if (k == 1) begin : g_head
      assign src      = beat_pad;
      assign src_vld  = bus.local_BCA_valid;
      assign src_last = bus.local_BCA_valid & bus.local_BCA_last;
`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
      assign src_thr  = bus.local_BCA_threshold;
`endif
    end else begin : g_link
      assign src      = g_layer[k-1].sum_q;
      assign src_vld  = g_layer[k-1].vld_q;
      assign src_last = g_layer[k-1].last_q;
`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
      assign src_thr  = g_layer[k-1].thr_q;
`endif
    end

    always_comb begin
      sum_d = '0;
      for (int unsigned j = 0; j < NumOut; j++) begin
        sum_d[j*OutW +: OutW] = OutW'(src[2*j*InW +: InW]) + OutW'(src[(2*j+1)*InW +: InW]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q  <= '0;
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end else if (!stall) begin
        sum_q  <= sum_d;
        vld_q  <= src_vld;
        last_q <= src_last;
      end
    end

`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
    // Threshold rides with its beat so back-to-back frames keep their own limit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        thr_q <= '0;
      end else if (!stall) begin
        thr_q <= src_thr;
      end
    end
`endif
  end

  logic [NumLayers:0]       tree_cnt;
  logic                     tree_vld;
  logic                     tree_last;
  logic [WID_CountResult-1:0] beat_cnt;

  assign tree_cnt  = g_layer[NumLayers].sum_q;
  assign tree_vld  = g_layer[NumLayers].vld_q;
  assign tree_last = g_layer[NumLayers].last_q;
  assign beat_cnt  = WID_CountResult'(tree_cnt);

  logic [WID_Accum-1:0] acc_q, acc_d;
  logic [WID_Accum-1:0] beats_q, beats_d;
  logic                 ovf_q, ovf_d;
  logic [WID_Accum-1:0] res_q, res_d;
  logic [WID_Accum-1:0] res_beats_q, res_beats_d;
  logic                 res_ovf_q, res_ovf_d;

  logic [WID_Accum:0]   sum_wide;
  logic [WID_Accum:0]   beats_wide;
  logic [WID_Accum-1:0] sum_sat;
  logic [WID_Accum-1:0] beats_sat;
  logic                 carry;

  assign sum_wide   = {1'b0, acc_q} + (WID_Accum + 1)'(beat_cnt);
  assign carry      = sum_wide[WID_Accum];
  assign sum_sat    = carry ? '1 : sum_wide[WID_Accum-1:0];
  assign beats_wide = {1'b0, beats_q} + OneWide;
  assign beats_sat  = beats_wide[WID_Accum] ? '1 : beats_wide[WID_Accum-1:0];

`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
  logic above_q, above_d;
`endif

  always_comb begin
    acc_d       = acc_q;
    beats_d     = beats_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    res_beats_d = res_beats_q;
    res_ovf_d   = res_ovf_q;
    out_valid_d = out_valid_q;
`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
    above_d     = above_q;
`endif
    if (!stall) begin
      // Not stalled means any held result is being taken now; a completing frame reloads.
      out_valid_d = tree_vld & tree_last;
      if (tree_vld) begin
        if (tree_last) begin
          res_d       = sum_sat;
          res_beats_d = beats_sat;
          res_ovf_d   = ovf_q | carry;
`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
          above_d     = sum_sat > g_layer[NumLayers].thr_q;
`endif
          acc_d       = '0;
          beats_d     = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d       = sum_sat;
          beats_d     = beats_sat;
          ovf_d       = ovf_q | carry;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      beats_q     <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      res_beats_q <= '0;
      res_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      res_beats_q <= res_beats_d;
      res_ovf_q   <= res_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      above_q <= 1'b0;
    end else begin
      above_q <= above_d;
    end
  end

  assign bus.BCA_local_above = above_q;
`endif

  assign bus.BCA_local_result   = res_q;
  assign bus.BCA_local_beats    = res_beats_q;
  assign bus.BCA_local_overflow = res_ovf_q;
  assign bus.BCA_local_valid    = out_valid_q;

endmodule

// File: tb/tb_bit_count_accumulator.sv
// Drives three configurations (32/16, 32/6, 20/16) with one stimulus stream and
// scores every frame result against a popcount/saturation reference model.
module tb_bit_count_accumulator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] in_data   = '0;
  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_thr    = '0;
  bit          rand_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  bit_count_accumulator_if #(.WID_CountRange(32), .WID_Accum(16)) bus_a ();
  bit_count_accumulator_if #(.WID_CountRange(32), .WID_Accum(6))  bus_b ();
  bit_count_accumulator_if #(.WID_CountRange(20), .WID_Accum(16)) bus_c ();

  assign bus_a.local_BCA_bitstream = in_data;
  assign bus_b.local_BCA_bitstream = in_data;
  assign bus_c.local_BCA_bitstream = in_data[19:0];
  assign bus_a.local_BCA_valid = in_valid;
  assign bus_b.local_BCA_valid = in_valid;
  assign bus_c.local_BCA_valid = in_valid;
  assign bus_a.local_BCA_last  = in_last;
  assign bus_b.local_BCA_last  = in_last;
  assign bus_c.local_BCA_last  = in_last;
  assign bus_a.local_BCA_ready = out_ready;
  assign bus_b.local_BCA_ready = out_ready;
  assign bus_c.local_BCA_ready = out_ready;

  bit_count_accumulator #(.WID_CountRange(32), .WID_Accum(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  bit_count_accumulator #(.WID_CountRange(32), .WID_Accum(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );
  bit_count_accumulator #(.WID_CountRange(20), .WID_Accum(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c)
  );

  logic [15:0] obs_res   [3];
  logic [15:0] obs_beats [3];
  logic        obs_ovf   [3];
  logic        obs_vld   [3];
  logic        obs_rdy   [3];
  logic        obs_above [3];

  assign obs_res[0]   = bus_a.BCA_local_result;
  assign obs_res[1]   = {10'b0, bus_b.BCA_local_result};
  assign obs_res[2]   = bus_c.BCA_local_result;
  assign obs_beats[0] = bus_a.BCA_local_beats;
  assign obs_beats[1] = {10'b0, bus_b.BCA_local_beats};
  assign obs_beats[2] = bus_c.BCA_local_beats;
  assign obs_ovf[0]   = bus_a.BCA_local_overflow;
  assign obs_ovf[1]   = bus_b.BCA_local_overflow;
  assign obs_ovf[2]   = bus_c.BCA_local_overflow;
  assign obs_vld[0]   = bus_a.BCA_local_valid;
  assign obs_vld[1]   = bus_b.BCA_local_valid;
  assign obs_vld[2]   = bus_c.BCA_local_valid;
  assign obs_rdy[0]   = bus_a.BCA_local_ready;
  assign obs_rdy[1]   = bus_b.BCA_local_ready;
  assign obs_rdy[2]   = bus_c.BCA_local_ready;
`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
  assign bus_a.local_BCA_threshold = in_thr;
  assign bus_b.local_BCA_threshold = in_thr[5:0];
  assign bus_c.local_BCA_threshold = in_thr;
  assign obs_above[0] = bus_a.BCA_local_above;
  assign obs_above[1] = bus_b.BCA_local_above;
  assign obs_above[2] = bus_c.BCA_local_above;
`else
  assign obs_above[0] = 1'b0;
  assign obs_above[1] = 1'b0;
  assign obs_above[2] = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0][15:0] res;
    logic [2:0][15:0] beats;
    logic [2:0]       ovf;
    logic [2:0]       above;
  } exp_t;

  exp_t exp_q[$];
  int   m_acc   [3];
  int   m_beats [3];
  bit   m_ovf   [3];
  exp_t mon_e;
  int   mon_sum;
  logic mon_stall;

  function automatic int max_of(input int k);
    return (k == 1) ? 63 : 65535;
  endfunction

  function automatic logic [31:0] mask_of(input int k);
    return (k == 2) ? 32'h000F_FFFF : 32'hFFFF_FFFF;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
        m_acc[k] = 0; m_beats[k] = 0; m_ovf[k] = 1'b0;
      end
    end else begin
      mon_stall = obs_vld[0] & ~out_ready;
      for (int k = 0; k < 3; k++) check($sformatf("ready[%0d]", k), obs_rdy[k], !mon_stall);
      if (obs_vld[0]) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", obs_vld[0], 0);
        end else begin
          mon_e = exp_q[0];
          for (int k = 0; k < 3; k++) begin
            check($sformatf("valid[%0d]", k), obs_vld[k], 1);
            check($sformatf("result[%0d]", k), obs_res[k], mon_e.res[k]);
            check($sformatf("beats[%0d]", k), obs_beats[k], mon_e.beats[k]);
            check($sformatf("overflow[%0d]", k), obs_ovf[k], mon_e.ovf[k]);
`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
            check($sformatf("above[%0d]", k), obs_above[k], mon_e.above[k]);
`endif
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && obs_rdy[0]) begin
        for (int k = 0; k < 3; k++) begin
          mon_sum = m_acc[k] + $countones(in_data & mask_of(k));
          if (mon_sum > max_of(k)) begin
            mon_sum  = max_of(k);
            m_ovf[k] = 1'b1;
          end
          m_beats[k] = (m_beats[k] + 1 > max_of(k)) ? max_of(k) : m_beats[k] + 1;
          if (in_last) begin
            mon_e.res[k]   = 16'(mon_sum);
            mon_e.beats[k] = 16'(m_beats[k]);
            mon_e.ovf[k]   = m_ovf[k];
            mon_e.above[k] = mon_sum > int'(in_thr & 16'(max_of(k)));
            m_acc[k] = 0; m_beats[k] = 0; m_ovf[k] = 1'b0;
          end else begin
            m_acc[k] = mon_sum;
          end
        end
        if (in_last) exp_q.push_back(mon_e);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // ---------------- driver helpers (called at posedge+1) ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last, input logic [15:0] thr);
    bit acc;
    int guard;
    in_data  = data;
    in_last  = last;
    in_thr   = thr;
    in_valid = 1'b1;
    guard    = 0;
    do begin
      @(negedge clk);
      acc = in_valid & obs_rdy[0];
      sync();
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("accept_timeout", 32'(acc), 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!obs_vld[0] && lat < 100);
    if (!obs_vld[0]) check("valid_timeout", obs_vld[0], 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int lat;

  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_valid", obs_vld[k], 0);
      check("reset_result", obs_res[k], 0);
      check("reset_beats", obs_beats[k], 0);
      check("reset_overflow", obs_ovf[k], 0);
      check("reset_above", obs_above[k], 0);
    end
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", obs_rdy[0], 1);
    sync();

    // Single full beat: latency and values
    send_beat(32'hFFFF_FFFF, 1'b1, 16'd0);
    wait_valid(lat);
    check("latency_32", lat, 6);
    check("single_result", obs_res[0], 32);
    check("single_beats", obs_beats[0], 1);
    check("single_ovf", obs_ovf[0], 0);
    @(negedge clk);
    check("single_pulse", obs_vld[0], 0);
    sync();

    // Three-beat frame
    send_beat(32'hFFFF_0000, 1'b0, 16'd0);
    send_beat(32'h0000_0001, 1'b0, 16'd0);
    send_beat(32'h0000_0000, 1'b1, 16'd0);
    wait_valid(lat);
    check("three_result", obs_res[0], 17);
    check("three_beats", obs_beats[0], 3);
    @(negedge clk);
    check("three_pulse", obs_vld[0], 0);
    sync();

    // Narrow accumulator saturation, then a clean frame
    repeat (2) send_beat(32'hFFFF_FFFF, 1'b0, 16'd0);
    send_beat(32'hFFFF_FFFF, 1'b1, 16'd0);
    wait_valid(lat);
    check("sat_result", obs_res[1], 63);
    check("sat_beats", obs_beats[1], 3);
    check("sat_ovf", obs_ovf[1], 1);
    check("wide_result", obs_res[0], 96);
    sync();
    send_beat(32'h0000_000F, 1'b1, 16'd0);
    wait_valid(lat);
    check("after_sat_result", obs_res[1], 4);
    check("after_sat_ovf", obs_ovf[1], 0);
    sync();

    // Output stall with back-to-back single-beat frames
    out_ready = 1'b0;
    send_beat(32'h0000_000F, 1'b1, 16'd0);
    send_beat(32'h0000_00FF, 1'b1, 16'd0);
    wait_valid(lat);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_ready", obs_rdy[0], 0);
      check("stall_result", obs_res[0], 4);
    end
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    check("release_result", obs_res[0], 4);
    @(negedge clk);
    check("b2b_valid", obs_vld[0], 1);
    check("b2b_result", obs_res[0], 8);
    sync();

    // 20-bit width: padded tree, same depth
    send_beat(32'h000F_FFFF, 1'b1, 16'd0);
    wait_valid(lat);
    check("latency_20", lat, 6);
    check("w20_valid", obs_vld[2], 1);
    check("w20_result", obs_res[2], 20);
    sync();

    // Reset in the middle of a frame discards it
    send_beat(32'h1234_5678, 1'b0, 16'd0);
    send_beat(32'hFFFF_FFFF, 1'b0, 16'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_valid", obs_vld[0], 0);
    check("midreset_result", obs_res[0], 0);
    sync();
    rst_n = 1'b1;
    send_beat(32'h0000_0003, 1'b1, 16'd0);
    wait_valid(lat);
    check("fresh_result", obs_res[0], 2);
    check("fresh_beats", obs_beats[0], 1);
    sync();

`ifdef BIT_COUNT_ACCUMULATOR_THRESHOLD_EN
    send_beat(32'h0001_FFFF, 1'b1, 16'd16);
    wait_valid(lat);
    check("thr_above_17", obs_above[0], 1);
    sync();
    send_beat(32'h0000_FFFF, 1'b1, 16'd16);
    wait_valid(lat);
    check("thr_above_16", obs_above[0], 0);
    sync();
`endif

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      int sel;
      sel = $urandom_range(0, 3);
      d = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) sync();
      send_beat(d, ($urandom_range(0, 3) == 0), 16'($urandom_range(0, 48)));
    end
    // Long frame to saturate the narrow beat counter
    for (int n = 0; n < 70; n++) send_beat($urandom, (n == 69), 16'($urandom_range(0, 48)));
    send_beat($urandom, 1'b1, 16'd10);

    rand_ready = 1'b0;
    sync();
    out_ready = 1'b1;
    for (int n = 0; n < 100 && (exp_q.size() != 0 || obs_vld[0]); n++) sync();
    check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
